// File: rtl/interrupt_sequencer.sv
// 8259A-style interrupt sequencer: INT/INTA handshake, ISR ownership, EOI and rotation.
// Define PIC_AUTO_EOI_EN to add the auto-EOI strap input and rotate-on-AEOI state.
module interrupt_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic       ocw2_valid,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  input  logic [4:0] vector_base,
`ifdef PIC_AUTO_EOI_EN
  input  logic       aeoi_mode,
`endif
  output logic       int_out,
  output logic [7:0] clear_irr,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] vector_out,
  output logic       vector_oe,
  output logic       spurious
);

  localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_ACK1,
    S_ACK2
  } state_e;

  state_e        state_q, state_d;
  logic          inta_prev_q;
  logic          int_out_q, int_out_d;
  logic [7:0]    clear_irr_q, clear_irr_d;
  logic [7:0]    isr_q, isr_d;
  logic [2:0]    rot_q, rot_d;
  logic [2:0]    level_q, level_d;
  logic [7:0]    vector_out_q, vector_out_d;
  logic          vector_oe_q, vector_oe_d;
  logic          spurious_q, spurious_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ocw_v_q;
  logic [2:0]    ocw_cmd_q;
  logic [2:0]    ocw_lvl_q;

  logic          inta_fall, inta_rise;
  logic          req_any;
  logic [2:0]    req_lvl;
  logic [7:0]    hlis;
  logic [2:0]    hlis_lvl;
  logic          hlis_found;
  logic [2:0]    scan_idx;

  logic [7:0]    fsm_set, fsm_clr;
  logic          fsm_rot_wr;
  logic [7:0]    ocw_clr;
  logic          ocw_rot_wr;
  logic [2:0]    ocw_rot_val;

`ifdef PIC_AUTO_EOI_EN
  logic          aeoi_en_q;
  logic          rot_aeoi_q, rot_aeoi_d;
`endif

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;
  assign req_any   = |interrupt;
  assign req_lvl   = encode(interrupt);

  // Level rot_q is lowest priority, so the scan begins one past it and wraps.
  always_comb begin
    hlis       = '0;
    hlis_lvl   = '0;
    hlis_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      scan_idx = rot_q + 3'(k);
      if (!hlis_found && isr_q[scan_idx]) begin
        hlis_found = 1'b1;
        hlis_lvl   = scan_idx;
      end
    end
    if (hlis_found) hlis[hlis_lvl] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    int_out_d    = int_out_q;
    clear_irr_d  = '0;
    level_d      = level_q;
    spurious_d   = spurious_q;
    vector_out_d = vector_out_q;
    vector_oe_d  = vector_oe_q;
    cnt_d        = cnt_q;
    fsm_set      = '0;
    fsm_clr      = '0;
    fsm_rot_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        vector_oe_d = 1'b0;
        if (req_any) begin
          state_d   = S_PEND;
          int_out_d = 1'b1;
        end
      end
      S_PEND: begin
        if (inta_fall) begin
          state_d   = S_ACK1;
          int_out_d = 1'b0;
          cnt_d     = '0;
          if (req_any) begin
            level_d          = req_lvl;
            fsm_set[req_lvl] = 1'b1;
            clear_irr_d      = interrupt;
            spurious_d       = 1'b0;
          end else begin
            level_d    = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (inta_fall) begin
          state_d      = S_ACK2;
          vector_out_d = {vector_base, level_q};
          vector_oe_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          state_d     = S_IDLE;
          vector_oe_d = 1'b0;
`ifdef PIC_AUTO_EOI_EN
          if (aeoi_en_q && !spurious_q) begin
            fsm_clr[level_q] = 1'b1;
            fsm_rot_wr       = rot_aeoi_q;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ocw_clr     = '0;
    ocw_rot_wr  = 1'b0;
    ocw_rot_val = '0;
`ifdef PIC_AUTO_EOI_EN
    rot_aeoi_d  = rot_aeoi_q;
`endif
    if (ocw_v_q) begin
      case (ocw_cmd_q)
        3'b001: ocw_clr = hlis;
        3'b011: ocw_clr[ocw_lvl_q] = 1'b1;
        3'b101: begin
          if (hlis_found) begin
            ocw_clr     = hlis;
            ocw_rot_wr  = 1'b1;
            ocw_rot_val = hlis_lvl;
          end
        end
        3'b111: begin
          ocw_clr[ocw_lvl_q] = 1'b1;
          ocw_rot_wr         = 1'b1;
          ocw_rot_val        = ocw_lvl_q;
        end
        3'b110: begin
          ocw_rot_wr  = 1'b1;
          ocw_rot_val = ocw_lvl_q;
        end
`ifdef PIC_AUTO_EOI_EN
        3'b100: rot_aeoi_d = 1'b1;
        3'b000: rot_aeoi_d = 1'b0;
`endif
        default: ;
      endcase
    end
  end

  // Set is OR'd after the clears so a same-cycle set of a cleared bit wins.
  always_comb begin
    isr_d = (isr_q & ~(ocw_clr | fsm_clr)) | fsm_set;
    rot_d = rot_q;
    if (fsm_rot_wr) rot_d = level_q;
    if (ocw_rot_wr) rot_d = ocw_rot_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      inta_prev_q  <= 1'b1;
      int_out_q    <= 1'b0;
      clear_irr_q  <= '0;
      isr_q        <= '0;
      rot_q        <= 3'd7;
      level_q      <= '0;
      vector_out_q <= '0;
      vector_oe_q  <= 1'b0;
      spurious_q   <= 1'b0;
      cnt_q        <= '0;
      ocw_v_q      <= 1'b0;
      ocw_cmd_q    <= '0;
      ocw_lvl_q    <= '0;
    end else begin
      state_q      <= state_d;
      inta_prev_q  <= inta_n;
      int_out_q    <= int_out_d;
      clear_irr_q  <= clear_irr_d;
      isr_q        <= isr_d;
      rot_q        <= rot_d;
      level_q      <= level_d;
      vector_out_q <= vector_out_d;
      vector_oe_q  <= vector_oe_d;
      spurious_q   <= spurious_d;
      cnt_q        <= cnt_d;
      ocw_v_q      <= ocw2_valid;
      if (ocw2_valid) begin
        ocw_cmd_q <= ocw2_cmd;
        ocw_lvl_q <= ocw2_level;
      end
    end
  end

`ifdef PIC_AUTO_EOI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aeoi_en_q  <= 1'b0;
      rot_aeoi_q <= 1'b0;
    end else begin
      aeoi_en_q  <= aeoi_mode;
      rot_aeoi_q <= rot_aeoi_d;
    end
  end
`endif

  assign int_out                  = int_out_q;
  assign clear_irr                = clear_irr_q;
  assign in_service_register      = isr_q;
  assign priority_rotate          = rot_q;
  assign highest_level_in_service = hlis;
  assign vector_out               = vector_out_q;
  assign vector_oe                = vector_oe_q;
  assign spurious                 = spurious_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench for interrupt_sequencer against a transaction-level PIC model.
module tb_interrupt_sequencer;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic [4:0] vector_base;
`ifdef PIC_AUTO_EOI_EN
  logic       aeoi_mode;
`endif
  logic       int_out;
  logic [7:0] clear_irr;
  logic [7:0] isr;
  logic [2:0] rot;
  logic [7:0] hlis;
  logic [7:0] vector_out;
  logic       vector_oe;
  logic       spurious;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state
  bit [7:0] m_isr;
  bit [2:0] m_rot;
  bit       m_spur;
  bit       m_rot_aeoi;
  bit       m_aeoi;

  interrupt_sequencer #(.ACK_TIMEOUT(T)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .interrupt                (interrupt),
    .inta_n                   (inta_n),
    .ocw2_valid               (ocw2_valid),
    .ocw2_cmd                 (ocw2_cmd),
    .ocw2_level               (ocw2_level),
    .vector_base              (vector_base),
`ifdef PIC_AUTO_EOI_EN
    .aeoi_mode                (aeoi_mode),
`endif
    .int_out                  (int_out),
    .clear_irr                (clear_irr),
    .in_service_register      (isr),
    .priority_rotate          (rot),
    .highest_level_in_service (hlis),
    .vector_out               (vector_out),
    .vector_oe                (vector_oe),
    .spurious                 (spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Highest in-service level = set bit with smallest distance past the rotation point.
  function automatic bit [7:0] m_hlis(input bit [7:0] v, input bit [2:0] r);
    int best = -1;
    int best_rank = 99;
    for (int l = 0; l < 8; l++) begin
      if (v[l]) begin
        int rank = (l + 7 - int'(r)) % 8;
        if (rank < best_rank) begin
          best_rank = rank;
          best = l;
        end
      end
    end
    return (best < 0) ? 8'h00 : 8'(1 << best);
  endfunction

  function automatic bit [2:0] m_idx(input bit [7:0] oh);
    for (int l = 0; l < 8; l++) if (oh[l]) return 3'(l);
    return 3'd0;
  endfunction

  task automatic m_ocw(input bit [2:0] cmd, input bit [2:0] lvl);
    bit [7:0] h;
    h = m_hlis(m_isr, m_rot);
    case (cmd)
      3'd1: m_isr &= ~h;
      3'd3: m_isr[lvl] = 1'b0;
      3'd5: if (h != 0) begin m_isr &= ~h; m_rot = m_idx(h); end
      3'd7: begin m_isr[lvl] = 1'b0; m_rot = lvl; end
      3'd6: m_rot = lvl;
`ifdef PIC_AUTO_EOI_EN
      3'd4: m_rot_aeoi = 1'b1;
      3'd0: m_rot_aeoi = 1'b0;
`endif
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_isr = '0; m_rot = 3'd7; m_spur = 1'b0; m_rot_aeoi = 1'b0; m_aeoi = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_isr"},  32'(isr),  32'(m_isr));
    check({tag, "_rot"},  32'(rot),  32'(m_rot));
    check({tag, "_hlis"}, 32'(hlis), 32'(m_hlis(m_isr, m_rot)));
  endtask

  task automatic do_ocw(input bit [2:0] cmd, input bit [2:0] lvl);
    ocw2_valid = 1'b1; ocw2_cmd = cmd; ocw2_level = lvl;
    tick();
    ocw2_valid = 1'b0;
    tick();
    m_ocw(cmd, lvl);
    check_state("ocw");
  endtask

  // Full two-pulse acknowledge; optional OCW2 lands on the same edge as the 1st INTA.
  task automatic do_ack(input bit [7:0] irq, input bit [4:0] vb, input bit drop,
                        input bit ocw_on, input bit [2:0] cmd, input bit [2:0] lvl,
                        input int unsigned gap);
    bit [2:0] exp_lvl;
    bit [7:0] exp_clr;
    interrupt = irq; vector_base = vb;
    if (ocw_on) begin
      ocw2_valid = 1'b1; ocw2_cmd = cmd; ocw2_level = lvl;
    end
    tick();
    ocw2_valid = 1'b0;
    check("int_out_raise", 32'(int_out), 32'd1);
    if (drop) interrupt = 8'h00;
    inta_n = 1'b0;
    tick();
    if (ocw_on) m_ocw(cmd, lvl);
    if (!drop) begin
      exp_lvl = m_idx(irq); exp_clr = irq; m_isr |= irq; m_spur = 1'b0;
    end else begin
      exp_lvl = 3'd7; exp_clr = 8'h00; m_spur = 1'b1;
    end
    check("int_out_ack1", 32'(int_out),   32'd0);
    check("clear_irr",    32'(clear_irr), 32'(exp_clr));
    check("spurious",     32'(spurious),  32'(m_spur));
    check("oe_ack1",      32'(vector_oe), 32'd0);
    check_state("ack1");
    interrupt = 8'h00; inta_n = 1'b1;
    tick();
    check("clear_irr_pulse", 32'(clear_irr), 32'd0);
    for (int unsigned g = 0; g < gap; g++) begin
      tick();
      check("oe_gap", 32'(vector_oe), 32'd0);
    end
    inta_n = 1'b0;
    tick();
    check("oe_ack2",    32'(vector_oe),  32'd1);
    check("vector_out", 32'(vector_out), 32'({vb, exp_lvl}));
    inta_n = 1'b1;
    tick();
`ifdef PIC_AUTO_EOI_EN
    if (m_aeoi && !drop) begin
      m_isr[exp_lvl] = 1'b0;
      if (m_rot_aeoi) m_rot = exp_lvl;
    end
`endif
    check("oe_release", 32'(vector_oe), 32'd0);
    check_state("ack2");
  endtask

  initial begin
    bit [2:0] rc;
    rst_n = 1'b0; interrupt = '0; inta_n = 1'b1; ocw2_valid = 1'b0;
    ocw2_cmd = '0; ocw2_level = '0; vector_base = '0;
`ifdef PIC_AUTO_EOI_EN
    aeoi_mode = 1'b0;
`endif
    m_reset();
    #12;
    check("rst_int_out",   32'(int_out),    32'd0);
    check("rst_clear_irr", 32'(clear_irr),  32'd0);
    check("rst_isr",       32'(isr),        32'd0);
    check("rst_rot",       32'(rot),        32'd7);
    check("rst_vec",       32'(vector_out), 32'd0);
    check("rst_oe",        32'(vector_oe),  32'd0);
    check("rst_spur",      32'(spurious),   32'd0);
    check("rst_hlis",      32'(hlis),       32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic acknowledge of IR2 with base 5'h01.
    do_ack(8'h04, 5'h01, 1'b0, 1'b0, 3'd0, 3'd0, 0);
    check("t1_isr", 32'(isr), 32'h04);

    // ISR=0x14, non-specific EOI then rotate-on-NS-EOI.
    do_ack(8'h10, 5'h01, 1'b0, 1'b0, 3'd0, 3'd0, 0);
    do_ocw(3'b001, 3'd0);
    check("t2_isr_a", 32'(isr), 32'h10);
    do_ocw(3'b101, 3'd0);
    check("t2_isr_b", 32'(isr), 32'h00);
    check("t2_rot",   32'(rot), 32'd4);

    // Request withdrawn before 1st INTA.
    do_ack(8'h20, 5'h1F, 1'b1, 1'b0, 3'd0, 3'd0, 0);
    check("t3_spur", 32'(spurious), 32'd1);
    check("t3_isr",  32'(isr),      32'h00);

    // 1st INTA only: timeout back to IDLE, ISR bit kept, no vector.
    interrupt = 8'h08;
    tick();
    inta_n = 1'b0;
    tick();
    m_isr |= 8'h08; m_spur = 1'b0;
    interrupt = 8'h00; inta_n = 1'b1;
    for (int unsigned i = 0; i < T + 2; i++) begin
      tick();
      check("t4_oe", 32'(vector_oe), 32'd0);
    end
    check("t4_isr", 32'(isr), 32'(m_isr));
    inta_n = 1'b0;
    tick();
    check("t4_idle_fall_oe",  32'(vector_oe), 32'd0);
    check("t4_idle_fall_clr", 32'(clear_irr), 32'd0);
    inta_n = 1'b1;
    tick();

    // 2nd INTA one cycle short of the timeout must still be accepted.
    do_ack(8'h02, 5'h0A, 1'b0, 1'b0, 3'd0, 3'd0, T - 3);

    // Specific EOI on the level being set in the same cycle: set wins.
    do_ack(8'h04, 5'h03, 1'b0, 1'b1, 3'b011, 3'd2, 0);
    check("t5_isr2", 32'(isr[2]), 32'd1);

    for (int unsigned it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 5) begin
        rc = 3'($urandom_range(0, 7));
        do_ack(8'(1 << $urandom_range(0, 7)), 5'($urandom), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 3) == 0), rc, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3));
      end else begin
        do_ocw(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
    end

    // Reset in the middle of the vector phase drops vector_oe without a clock.
    interrupt = 8'h01;
    tick();
    interrupt = 8'h00; inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("abort_oe_before", 32'(vector_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_oe",  32'(vector_oe), 32'd0);
    check("abort_isr", 32'(isr),       32'd0);
    m_reset();
    inta_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PIC_AUTO_EOI_EN
    aeoi_mode = 1'b1;
    tick();
    m_aeoi = 1'b1;
    do_ocw(3'b100, 3'd0);
    do_ack(8'h20, 5'h04, 1'b0, 1'b0, 3'd0, 3'd0, 0);
    check("t6_isr", 32'(isr), 32'h00);
    check("t6_rot", 32'(rot), 32'd5);
`else
    // Without auto-EOI, 100 is a no-op and the ISR bit survives acknowledge.
    do_ocw(3'b100, 3'd0);
    do_ack(8'h20, 5'h04, 1'b0, 1'b0, 3'd0, 3'd0, 0);
    check("t6_isr", 32'(isr), 32'h20);
    check("t6_rot", 32'(rot), 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
